// File: rtl/inst_fetch.sv
// Instruction fetch: holds the PC, issues word fetches, latches the returned word into the IR for decode.
// Latency: request in REQ, response in WAIT (1+ cycles), IR valid in HOLD; best case one instruction every 3 cycles.
// Backpressure: imem_req_ready stalls in REQ, id_ready stalls in HOLD; redirect overrides both and kills wrong-path data.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [5:0]  id_op,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [5:0]  id_funct
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_req;
  logic        kill;

  logic        req_fire;
  logic        resp_take;
  logic [31:0] redirect_pc_al;

  // A request is issued whenever REQ meets ready, even if a redirect lands in the same cycle.
  assign req_fire       = (state == REQ) && imem_req_ready;
  // Response goes to the IR only when it belongs to the current path.
  assign resp_take      = (state == WAIT) && imem_resp_valid && !kill && !redirect_valid;
  assign redirect_pc_al = {redirect_pc[31:2], 2'b00};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; redirect outranks every other event.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (imem_req_ready) state_nxt = WAIT;
      WAIT: begin
        if (imem_resp_valid) state_nxt = (kill || redirect_valid) ? REQ : HOLD;
      end
      HOLD: if (redirect_valid || id_ready) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; id_valid is suppressed while a redirect discards the IR.
  always_comb begin
    imem_req_valid = (state == REQ);
    id_valid       = (state == HOLD) && !redirect_valid;
  end

  // PC, in-flight request address and kill flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      pc_req <= RESET_PC;
      kill   <= 1'b0;
    end else begin
      if (redirect_valid)  pc <= redirect_pc_al;
      else if (req_fire)   pc <= pc + 32'd4;
      if (req_fire)        pc_req <= pc;
      if (req_fire && redirect_valid) begin
        kill <= 1'b1;
      end else if (state == WAIT) begin
        if (imem_resp_valid)     kill <= 1'b0;
        else if (redirect_valid) kill <= 1'b1;
      end
    end
  end

  // Instruction register and its fetch address; held until the next accepted response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_instr <= 32'h0;
      id_pc    <= 32'h0;
    end else if (resp_take) begin
      id_instr <= imem_resp_data;
      id_pc    <= pc_req;
    end
  end

  assign imem_addr = pc;
  assign id_op     = id_instr[31:26];
  assign id_rs     = id_instr[25:21];
  assign id_rt     = id_instr[20:16];
  assign id_rd     = id_instr[15:11];
  assign id_funct  = id_instr[5:0];

endmodule
